forwarding_scoreboard: RTL and testbench
========================================

// Module: forwarding_scoreboard
// PURPOSE
//  Parametrised EX-stage operand forwarding with load-use stall and hold buffering.
//  Compares NRD consumer source registers against NSRC producer stages; youngest ready match forwards.
//  Unready match (load in flight) stalls; forwarded values are captured while EX is frozen.
//  Watchdog flags runaway stalls; a saturating counter totals stall cycles.
// PARAMETERS
//  DW        32  data width
//  NRD       2   consumer source ports (rs, rt, ...)
//  NSRC      2   producer stages; index 0 = youngest (MEM), NSRC-1 = oldest
//  MAX_STALL 15  consecutive stall cycles before err_timeout
//  CNTW      16  stall_cnt width
// PORTS
//  CLK         in   1        clock, rising edge
//  RST         in   1        synchronous reset, active-high
//  ex_valid    in   1        EX holds a real instruction
//  ex_src      in   NRD*5    consumer source register indices
//  ex_advance  in   1        EX instruction leaves EX this edge
//  flush       in   1        kill EX instruction (branch/jump)
//  prod_wen    in   NSRC     producer writes register file
//  prod_dest   in   NSRC*5   producer destination register
//  prod_ready  in   NSRC     producer result available (0 = load pending)
//  prod_data   in   NSRC*DW  producer result
//  fwd_sel     out  NRD      1 = use fwd_data for port, 0 = register file
//  fwd_data    out  NRD*DW   forwarded operand; 0 when fwd_sel=0
//  stall       out  1        freeze IF/ID/EX
//  err_timeout out  1        sticky watchdog flag
//  stall_cnt   out  CNTW     total stall cycles, saturating
// BEHAVIOUR
//  Reset: hold_v=0, FSM=RUN, run counter=0, stall_cnt=0, err_timeout=0.
//  Match(p,s): prod_wen[s] && prod_dest[s]!=0 && prod_dest[s]==ex_src[p]; r0 never matches.
//  Per port p, lowest matching s wins (youngest). Older matches ignored even if younger unready.
//  Winner ready -> fwd_sel=1, fwd_data=prod_data[s]. Winner unready -> hazard[p]=1.
//  No match and hold_v[p] && hold_tag[p]==ex_src[p] -> fwd_sel=1, fwd_data=hold_data[p].
//  Otherwise fwd_sel=0, fwd_data=0. ex_valid=0 -> fwd_sel=0, hazard=0.
//  stall = |hazard (combinational, same cycle); fwd outputs also combinational.
//  Hold capture, registered: if ex_valid && !ex_advance && port forwards from a producer,
//   hold_v[p]<=1, hold_tag<=ex_src[p], hold_data<=forwarded value (refreshed each frozen cycle).
//  Hold clear: ex_advance or flush clears all hold_v next edge. Priority: RST > flush > advance > capture.
//  FSM RUN: stall -> STALL, run counter<=1. STALL: !stall -> RUN, counter<=0; else counter+1.
//  Counter reaching MAX_STALL sets err_timeout (sticky until RST); FSM -> ERR.
//  ERR: forwarding/stall continue normally; only RST leaves ERR.
//  stall_cnt +1 each cycle stall=1, saturates at 2^CNTW-1, no wrap.
//  flush with stall=1: hazard still reported that cycle; hold cleared next edge.
//  RST mid-stall: all state cleared next edge; stall reverts to pure combinational value.
// TESTING
//  MEM wen r5 ready data 0xDEADBEEF, ex_src[0]=5 -> fwd_sel[0]=1, fwd_data=0xDEADBEEF, stall=0.
//  MEM and WB both write r5 (0x1111/0x2222) -> fwd_data=0x1111 (youngest wins).
//  MEM r7 ready=0 for 3 cycles, ex_src[1]=7 -> stall=1 three cycles, then forwards; stall_cnt=3.
//  prod_dest=0, ex_src=0 -> fwd_sel=0, stall=0.
//  WB r3=0x55, ex_advance=0; next cycle producers idle -> fwd_data=0x55 from hold; after advance fwd_sel=0.
//  MAX_STALL=4, ready never set -> err_timeout=1 at 4th stall cycle, stays 1; RST clears all.

Source files
------------

// File: rtl/forwarding_scoreboard.sv
// EX-stage operand forwarding with load-use stall detection and hold buffering.
// A stall watchdog and a saturating stall-cycle counter run alongside it.
module forwarding_scoreboard #(
    parameter int DW        = 32,
    parameter int NRD       = 2,
    parameter int NSRC      = 2,
    parameter int MAX_STALL = 15,
    parameter int CNTW      = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                ex_valid,
    input  logic [NRD*5-1:0]    ex_src,
    input  logic                ex_advance,
    input  logic                flush,
    input  logic [NSRC-1:0]     prod_wen,
    input  logic [NSRC*5-1:0]   prod_dest,
    input  logic [NSRC-1:0]     prod_ready,
    input  logic [NSRC*DW-1:0]  prod_data,
    output logic [NRD-1:0]      fwd_sel,
    output logic [NRD*DW-1:0]   fwd_data,
    output logic                stall,
    output logic                err_timeout,
    output logic [CNTW-1:0]     stall_cnt
);

    localparam int RW = $clog2(MAX_STALL + 1);
    localparam logic [RW-1:0] MAX_C = RW'(MAX_STALL);
    localparam logic [RW-1:0] ONE_C = RW'(1);

    typedef enum logic [1:0] {S_RUN, S_STALL, S_ERR} state_t;

    state_t                state_q;
    logic [RW-1:0]         run_q;
    logic                  err_q;
    logic [CNTW-1:0]       cnt_q, cnt_d;
    logic [NRD-1:0]        hold_v_q;
    logic [NRD-1:0][4:0]   hold_tag_q;
    logic [NRD-1:0][DW-1:0] hold_data_q;
    logic [NRD-1:0]        hazard;
    logic [NRD-1:0]        prod_fwd;

    // Per port: scan from youngest producer; the first match decides, even if unready.
    always_comb begin : fwd_comb
        logic       found;
        logic [4:0] src;
        found    = 1'b0;
        src      = '0;
        fwd_sel  = '0;
        fwd_data = '0;
        hazard   = '0;
        prod_fwd = '0;
        if (ex_valid) begin
            for (int p = 0; p < NRD; p++) begin
                src   = ex_src[p*5 +: 5];
                found = 1'b0;
                for (int s = 0; s < NSRC; s++) begin
                    if (!found && prod_wen[s] && (prod_dest[s*5 +: 5] != 5'd0) &&
                        (prod_dest[s*5 +: 5] == src)) begin
                        found = 1'b1;
                        if (prod_ready[s]) begin
                            fwd_sel[p]            = 1'b1;
                            fwd_data[p*DW +: DW]  = prod_data[s*DW +: DW];
                            prod_fwd[p]           = 1'b1;
                        end else begin
                            hazard[p] = 1'b1;
                        end
                    end
                end
                if (!found && hold_v_q[p] && (hold_tag_q[p] == src)) begin
                    fwd_sel[p]           = 1'b1;
                    fwd_data[p*DW +: DW] = hold_data_q[p];
                end
            end
        end
    end

    assign stall       = |hazard;
    assign err_timeout = err_q;
    assign stall_cnt   = cnt_q;
    assign cnt_d       = (stall && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            hold_v_q <= '0;
        end else if (flush || ex_advance) begin
            hold_v_q <= '0;
        end else if (ex_valid) begin
            for (int p = 0; p < NRD; p++) begin
                if (prod_fwd[p]) hold_v_q[p] <= 1'b1;
            end
        end
    end

    // Captured values are refreshed every frozen cycle so a producer leaving the pipe is not lost.
    always_ff @(posedge CLK) begin
        for (int p = 0; p < NRD; p++) begin
            if (ex_valid && !ex_advance && !flush && prod_fwd[p]) begin
                hold_tag_q[p]  <= ex_src[p*5 +: 5];
                hold_data_q[p] <= fwd_data[p*DW +: DW];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_RUN;
            run_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            case (state_q)
                S_RUN: begin
                    if (stall) begin
                        run_q <= ONE_C;
                        if (ONE_C >= MAX_C) begin
                            err_q   <= 1'b1;
                            state_q <= S_ERR;
                        end else begin
                            state_q <= S_STALL;
                        end
                    end
                end
                S_STALL: begin
                    if (!stall) begin
                        run_q   <= '0;
                        state_q <= S_RUN;
                    end else begin
                        run_q <= run_q + 1'b1;
                        if ((run_q + 1'b1) >= MAX_C) begin
                            err_q   <= 1'b1;
                            state_q <= S_ERR;
                        end
                    end
                end
                default: begin
                    err_q   <= 1'b1;
                    state_q <= S_ERR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Directed bench for forwarding_scoreboard: stimulus queues expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_forwarding_scoreboard;

    localparam int DW   = 32;
    localparam int NRD  = 2;
    localparam int NSRC = 2;
    localparam int CNTW = 4;

    logic                CLK = 1'b0;
    logic                RST;
    logic                ex_valid;
    logic [NRD*5-1:0]    ex_src;
    logic                ex_advance;
    logic                flush;
    logic [NSRC-1:0]     prod_wen;
    logic [NSRC*5-1:0]   prod_dest;
    logic [NSRC-1:0]     prod_ready;
    logic [NSRC*DW-1:0]  prod_data;
    logic [NRD-1:0]      fwd_sel;
    logic [NRD*DW-1:0]   fwd_data;
    logic                stall;
    logic                err_timeout;
    logic [CNTW-1:0]     stall_cnt;

    typedef struct {
        string       name;
        logic [1:0]  sel;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        st;
        logic        err;
        logic [3:0]  cnt;
    } exp_t;

    exp_t q[$];
    int   tests  = 0;
    int   failed = 0;

    forwarding_scoreboard #(
        .DW(DW), .NRD(NRD), .NSRC(NSRC), .MAX_STALL(4), .CNTW(CNTW)
    ) dut (
        .CLK(CLK), .RST(RST), .ex_valid(ex_valid), .ex_src(ex_src),
        .ex_advance(ex_advance), .flush(flush), .prod_wen(prod_wen),
        .prod_dest(prod_dest), .prod_ready(prod_ready), .prod_data(prod_data),
        .fwd_sel(fwd_sel), .fwd_data(fwd_data), .stall(stall),
        .err_timeout(err_timeout), .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string n, input string f, input logic [31:0] act, input logic [31:0] exv);
        tests++;
        if (act !== exv) begin
            failed++;
            $display("FAIL %s.%s actual=%0h required=%0h", n, f, act, exv);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (q.size() > 0) begin
                e = q.pop_front();
                check(e.name, "fwd_sel",  32'(fwd_sel),        32'(e.sel));
                check(e.name, "fwd_d0",   fwd_data[31:0],      e.d0);
                check(e.name, "fwd_d1",   fwd_data[63:32],     e.d1);
                check(e.name, "stall",    32'(stall),          32'(e.st));
                check(e.name, "err",      32'(err_timeout),    32'(e.err));
                check(e.name, "stall_cnt", 32'(stall_cnt),     32'(e.cnt));
            end
        end
    end

    task automatic idle();
        ex_valid   = 1'b0;
        ex_src     = '0;
        ex_advance = 1'b0;
        flush      = 1'b0;
        prod_wen   = '0;
        prod_dest  = '0;
        prod_ready = '0;
        prod_data  = '0;
    endtask

    task automatic prod(input int s, input logic [4:0] d, input logic r, input logic [31:0] v);
        prod_wen[s]            = 1'b1;
        prod_dest[s*5 +: 5]    = d;
        prod_ready[s]          = r;
        prod_data[s*DW +: DW]  = v;
    endtask

    task automatic expect_cyc(input string n, input logic [1:0] sel, input logic [31:0] d0,
                              input logic [31:0] d1, input logic st, input logic err,
                              input logic [3:0] cnt);
        exp_t e;
        e.name = n; e.sel = sel; e.d0 = d0; e.d1 = d1; e.st = st; e.err = err; e.cnt = cnt;
        q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        idle();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;

        idle();
        expect_cyc("reset", 2'b00, 0, 0, 0, 0, 0);

        idle(); ex_valid = 1; ex_src = {5'd0, 5'd5}; ex_advance = 1;
        prod(0, 5'd5, 1'b1, 32'hDEADBEEF);
        expect_cyc("mem_fwd", 2'b01, 32'hDEADBEEF, 0, 0, 0, 0);

        idle(); ex_valid = 1; ex_src = {5'd5, 5'd5}; ex_advance = 1;
        prod(0, 5'd5, 1'b1, 32'h1111); prod(1, 5'd5, 1'b1, 32'h2222);
        expect_cyc("youngest", 2'b11, 32'h1111, 32'h1111, 0, 0, 0);

        idle(); ex_valid = 1; ex_src = {5'd0, 5'd0}; ex_advance = 1;
        prod(0, 5'd0, 1'b1, 32'hAAAA); prod(1, 5'd0, 1'b1, 32'hBBBB);
        expect_cyc("r0", 2'b00, 0, 0, 0, 0, 0);

        for (int i = 0; i < 3; i++) begin
            idle(); ex_valid = 1; ex_src = {5'd7, 5'd1};
            prod(0, 5'd7, 1'b0, 32'h77);
            expect_cyc("load_use", 2'b00, 0, 0, 1, 0, 4'(i));
        end
        idle(); ex_valid = 1; ex_src = {5'd7, 5'd1}; ex_advance = 1;
        prod(0, 5'd7, 1'b1, 32'h77);
        expect_cyc("load_done", 2'b10, 0, 32'h77, 0, 0, 3);

        idle(); ex_valid = 1; ex_src = {5'd0, 5'd3};
        prod(1, 5'd3, 1'b1, 32'h55);
        expect_cyc("hold_cap", 2'b01, 32'h55, 0, 0, 0, 3);
        idle(); ex_valid = 1; ex_src = {5'd0, 5'd3};
        expect_cyc("hold_use", 2'b01, 32'h55, 0, 0, 0, 3);
        idle(); ex_valid = 1; ex_src = {5'd0, 5'd3}; ex_advance = 1;
        expect_cyc("hold_adv", 2'b01, 32'h55, 0, 0, 0, 3);
        idle(); ex_valid = 1; ex_src = {5'd0, 5'd3};
        expect_cyc("hold_clr", 2'b00, 0, 0, 0, 0, 3);

        idle(); ex_src = {5'd0, 5'd5};
        prod(0, 5'd5, 1'b0, 32'h99);
        expect_cyc("no_valid", 2'b00, 0, 0, 0, 0, 3);

        idle(); ex_valid = 1; ex_src = {5'd0, 5'd4};
        prod(0, 5'd4, 1'b1, 32'h44);
        expect_cyc("flush_cap", 2'b01, 32'h44, 0, 0, 0, 3);
        idle(); ex_valid = 1; ex_src = {5'd0, 5'd4}; flush = 1;
        expect_cyc("flush_hold", 2'b01, 32'h44, 0, 0, 0, 3);
        idle(); ex_valid = 1; ex_src = {5'd0, 5'd4};
        expect_cyc("flush_clr", 2'b00, 0, 0, 0, 0, 3);

        idle(); ex_valid = 1; ex_src = {5'd0, 5'd6}; flush = 1;
        prod(0, 5'd6, 1'b0, 32'h66); prod(1, 5'd6, 1'b1, 32'h600);
        expect_cyc("older_ign", 2'b00, 0, 0, 1, 0, 3);
        idle(); ex_valid = 1; ex_src = {5'd0, 5'd6};
        expect_cyc("post_flush", 2'b00, 0, 0, 0, 0, 4);

        for (int k = 0; k < 14; k++) begin
            idle(); ex_valid = 1; ex_src = {5'd0, 5'd7};
            prod(0, 5'd7, 1'b0, 32'h7);
            expect_cyc("timeout", 2'b00, 0, 0, 1, (k >= 4), ((4 + k) > 15) ? 4'd15 : 4'(4 + k));
        end

        idle(); ex_valid = 1; ex_src = {5'd0, 5'd7}; ex_advance = 1;
        prod(0, 5'd7, 1'b1, 32'h7);
        expect_cyc("err_fwd", 2'b01, 32'h7, 0, 0, 1, 15);

        idle(); RST = 1; ex_valid = 1; ex_src = {5'd0, 5'd7};
        prod(0, 5'd7, 1'b0, 32'h7);
        expect_cyc("rst_stall", 2'b00, 0, 0, 1, 1, 15);
        RST = 0; idle();
        expect_cyc("rst_clr", 2'b00, 0, 0, 0, 0, 0);

        for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge CLK);
        #1;
        if (q.size() > 0) begin
            tests++;
            failed++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time_limit_reached");
        $fatal(1, "watchdog");
    end

endmodule
